// File: rtl/cmd_uart_if_if.sv
// Command-side handshake bundle for cmd_uart_if: assembled command with its
// ready/clear pair, plus the response request and status signals.
interface cmd_uart_if_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;

  // Command processor side
  modport master (
    input  cmd, cmd_rdy, tx_busy, resp_sent,
    output clr_cmd_rdy, send_resp
  );

  // UART front end side
  modport slave (
    output cmd, cmd_rdy, tx_busy, resp_sent,
    input  clr_cmd_rdy, send_resp
  );
endinterface

// File: rtl/cmd_uart_if.sv
// Serial front end of the command path. Receives two UART bytes (high byte
// first) into a 16-bit command with a ready/clear handshake, and transmits a
// one-byte acknowledge on request. RX and TX run independently.
module cmd_uart_if #(
  parameter int          BAUD_DIV  = 2604,
  parameter logic [7:0]  RESP_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RX,
  output logic          TX,
  cmd_uart_if_if.slave  bus
);

  localparam logic [11:0] BAUD_FULL = 12'(BAUD_DIV);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic       {TX_IDLE, TX_XMIT} tx_state_e;

  // ---------------------------------------------------------------- RX sync
  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;
  logic rx_prev_q, rx_prev_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_comb begin
    rx_meta_d = RX;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  // Synchronizer flops preset to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  logic rx_fall;
  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // ---------------------------------------------------------------- RX FSM
  rx_state_e   rx_state_q, rx_state_d;
  logic [11:0] rx_timer_q, rx_timer_d;
  logic [2:0]  rx_bit_cnt_q, rx_bit_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_wait_hi_q, rx_wait_hi_d;
  logic        byte_ptr_q, byte_ptr_d;     // 0: expecting high byte, 1: low byte
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        cmd_set;
  logic        start_hi;
  logic        rx_expire;

  assign rx_expire = (rx_timer_q == 12'd1);

  // Receive sequencing, byte assembly and cmd_rdy set/clear arbitration
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_timer_d   = rx_timer_q;
    rx_bit_cnt_d = rx_bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_wait_hi_d = rx_wait_hi_q;
    byte_ptr_d   = byte_ptr_q;
    hi_byte_d    = hi_byte_q;
    cmd_d        = cmd_q;
    cmd_set      = 1'b0;
    start_hi     = 1'b0;

    if (rx_state_q != RX_IDLE && !rx_expire) begin
      rx_timer_d = rx_timer_q - 12'd1;
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_wait_hi_q) begin
          // After a framing error, re-arm only once the line reads idle
          if (rx_sync_q) rx_wait_hi_d = 1'b0;
        end else if (rx_fall) begin
          rx_state_d = RX_START;
          rx_timer_d = BAUD_HALF;
          start_hi   = ~byte_ptr_q;
        end
      end
      RX_START: begin
        if (rx_expire) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d   = RX_DATA;
            rx_timer_d   = BAUD_FULL;
            rx_bit_cnt_d = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_expire) begin
          rx_timer_d = BAUD_FULL;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_cnt_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_cnt_d = rx_bit_cnt_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (rx_expire) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            if (!byte_ptr_q) begin
              hi_byte_d  = rx_shift_q;
              byte_ptr_d = 1'b1;
            end else begin
              cmd_d      = {hi_byte_q, rx_shift_q};
              cmd_set    = 1'b1;
              byte_ptr_d = 1'b0;
            end
          end else begin
            rx_wait_hi_d = 1'b1;
            byte_ptr_d   = 1'b0;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // A completing command takes priority over any clear in the same cycle
    if (cmd_set) begin
      cmd_rdy_d = 1'b1;
    end else if (bus.clr_cmd_rdy || start_hi) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end
  end

  // RX state and command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RX_IDLE;
      rx_timer_q   <= '0;
      rx_bit_cnt_q <= '0;
      rx_shift_q   <= '0;
      rx_wait_hi_q <= 1'b0;
      byte_ptr_q   <= 1'b0;
      hi_byte_q    <= '0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_timer_q   <= rx_timer_d;
      rx_bit_cnt_q <= rx_bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_wait_hi_q <= rx_wait_hi_d;
      byte_ptr_q   <= byte_ptr_d;
      hi_byte_q    <= hi_byte_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_e   tx_state_q, tx_state_d;
  logic [11:0] tx_timer_q, tx_timer_d;
  logic [3:0]  tx_bit_cnt_q, tx_bit_cnt_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;
  logic        tx_busy_q, tx_busy_d;
  logic        resp_sent_q, resp_sent_d;
  logic        tx_expire;

  assign tx_expire = (tx_timer_q == 12'd1);

  // Response frame serializer; TX line and status are driven from flops
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_timer_d   = tx_timer_q;
    tx_bit_cnt_d = tx_bit_cnt_q;
    tx_shift_d   = tx_shift_q;
    tx_d         = tx_q;
    tx_busy_d    = tx_busy_q;
    resp_sent_d  = 1'b0;

    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (bus.send_resp) begin
          tx_state_d   = TX_XMIT;
          tx_shift_d   = {1'b1, RESP_BYTE, 1'b0};
          tx_d         = 1'b0;
          tx_busy_d    = 1'b1;
          tx_timer_d   = BAUD_FULL;
          tx_bit_cnt_d = '0;
        end
      end
      TX_XMIT: begin
        if (tx_expire) begin
          tx_timer_d = BAUD_FULL;
          if (tx_bit_cnt_q == 4'd9) begin
            tx_state_d  = TX_IDLE;
            tx_d        = 1'b1;
            tx_busy_d   = 1'b0;
            resp_sent_d = 1'b1;
          end else begin
            tx_bit_cnt_d = tx_bit_cnt_q + 4'd1;
            tx_shift_d   = {1'b1, tx_shift_q[9:1]};
            tx_d         = tx_shift_q[1];
          end
        end else begin
          tx_timer_d = tx_timer_q - 12'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= TX_IDLE;
      tx_timer_q   <= '0;
      tx_bit_cnt_q <= '0;
      tx_shift_q   <= '1;
      tx_q         <= 1'b1;
      tx_busy_q    <= 1'b0;
      resp_sent_q  <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_timer_q   <= tx_timer_d;
      tx_bit_cnt_q <= tx_bit_cnt_d;
      tx_shift_q   <= tx_shift_d;
      tx_q         <= tx_d;
      tx_busy_q    <= tx_busy_d;
      resp_sent_q  <= resp_sent_d;
    end
  end

  assign TX            = tx_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.tx_busy   = tx_busy_q;
  assign bus.resp_sent = resp_sent_q;

endmodule

// File: tb/tb_cmd_uart_if.sv
// Directed bench for cmd_uart_if at BAUD_DIV=16: command assembly, clear
// handshake, response framing, false start, framing error, overwrite and
// mid-frame reset. Inputs are driven and outputs sampled on the falling edge.
module tb_cmd_uart_if;

  localparam int BAUD = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic tx;

  int n_checks = 0;
  int n_errors = 0;

  cmd_uart_if_if bus();

  cmd_uart_if #(.BAUD_DIV(BAUD), .RESP_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .TX    (tx),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives start, 8 data bits LSB first, then the stop level held for
  // stop_cycles falling edges; the line is left at the stop level.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int stop_cycles);
    @(negedge clk);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop;
    repeat (stop_cycles) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] frame;
    int         pulses;
    int         resp_k;
    int         tx_low_after;

    rst_n = 1'b0;
    rx = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_tx", 32'(tx), 32'h1);
    check("rst_cmd", 32'(bus.cmd), 32'h0);
    check("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
    check("rst_tx_busy", 32'(bus.tx_busy), 32'h0);
    check("rst_resp_sent", 32'(bus.resp_sent), 32'h0);
    rst_n = 1'b1;
    idle(5);

    // 1: 0x40, 0x02 with exact cmd_rdy rise, then clear
    send_byte(8'h40, 1'b1, BAUD);
    send_byte(8'h02, 1'b1, 0);
    repeat (10) @(negedge clk);
    check("t1_rdy_before_stop", 32'(bus.cmd_rdy), 32'h0);
    @(negedge clk);
    check("t1_rdy_at_stop", 32'(bus.cmd_rdy), 32'h1);
    check("t1_cmd", 32'(bus.cmd), 32'h4002);
    repeat (5) @(negedge clk);
    pulse_clr();
    check("t1_rdy_cleared", 32'(bus.cmd_rdy), 32'h0);
    check("t1_cmd_held", 32'(bus.cmd), 32'h4002);

    // 2: response frame, timing of resp_sent, ignored mid-frame request
    idle(3);
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    check("t2_tx_fell", 32'(tx), 32'h0);
    check("t2_busy_rose", 32'(bus.tx_busy), 32'h1);
    frame = '0;
    pulses = 0;
    resp_k = 0;
    tx_low_after = 0;
    for (int k = 1; k <= 200; k++) begin
      bus.send_resp = (k == 40);
      if ((k % BAUD) == 8 && k < 10 * BAUD) frame[k / BAUD] = tx;
      if (bus.resp_sent) begin
        pulses++;
        if (pulses == 1) begin
          resp_k = k;
          check("t2_busy_at_resp", 32'(bus.tx_busy), 32'h0);
        end
      end
      if (k > 10 * BAUD && !tx) tx_low_after++;
      @(negedge clk);
    end
    bus.send_resp = 1'b0;
    check("t2_frame", 32'(frame), 32'h34A);
    check("t2_resp_delay", 32'(resp_k - 1), 32'd160);
    check("t2_resp_pulses", 32'(pulses), 32'd1);
    check("t2_no_second_frame", 32'(tx_low_after), 32'd0);
    check("t2_idle_busy", 32'(bus.tx_busy), 32'h0);

    // 3: 4-cycle glitch rejected, then 0x20, 0x3F
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check("t3_glitch_no_rdy", 32'(bus.cmd_rdy), 32'h0);
    send_byte(8'h20, 1'b1, BAUD);
    check("t3_hi_no_rdy", 32'(bus.cmd_rdy), 32'h0);
    send_byte(8'h3F, 1'b1, BAUD);
    check("t3_rdy", 32'(bus.cmd_rdy), 32'h1);
    check("t3_cmd", 32'(bus.cmd), 32'h203F);
    pulse_clr();

    // 4: framing error on 0x12 discards it, then 0x00, 0x01
    send_byte(8'h12, 1'b0, BAUD);
    idle(20);
    check("t4_bad_no_rdy", 32'(bus.cmd_rdy), 32'h0);
    send_byte(8'h00, 1'b1, BAUD);
    check("t4_hi_no_rdy", 32'(bus.cmd_rdy), 32'h0);
    check("t4_cmd_unchanged", 32'(bus.cmd), 32'h203F);
    send_byte(8'h01, 1'b1, BAUD);
    check("t4_rdy", 32'(bus.cmd_rdy), 32'h1);
    check("t4_cmd", 32'(bus.cmd), 32'h0001);
    pulse_clr();

    // 5: unconsumed 0x6000 overwritten by 0x1234; clear on the set cycle
    send_byte(8'h60, 1'b1, BAUD);
    send_byte(8'h00, 1'b1, BAUD);
    check("t5_first_rdy", 32'(bus.cmd_rdy), 32'h1);
    check("t5_first_cmd", 32'(bus.cmd), 32'h6000);
    send_byte(8'h12, 1'b1, BAUD);
    check("t5_rdy_dropped", 32'(bus.cmd_rdy), 32'h0);
    check("t5_cmd_kept", 32'(bus.cmd), 32'h6000);
    send_byte(8'h34, 1'b1, 0);
    repeat (10) @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check("t5_set_wins", 32'(bus.cmd_rdy), 32'h1);
    check("t5_cmd", 32'(bus.cmd), 32'h1234);
    repeat (5) @(negedge clk);
    pulse_clr();

    // 6: reset during the low byte, then 0xAB, 0xCD
    send_byte(8'h55, 1'b1, BAUD);
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_cmd", 32'(bus.cmd), 32'h0);
    check("t6_rst_rdy", 32'(bus.cmd_rdy), 32'h0);
    rst_n = 1'b1;
    idle(20);
    send_byte(8'hAB, 1'b1, BAUD);
    check("t6_hi_no_rdy", 32'(bus.cmd_rdy), 32'h0);
    send_byte(8'hCD, 1'b1, BAUD);
    check("t6_rdy", 32'(bus.cmd_rdy), 32'h1);
    check("t6_cmd", 32'(bus.cmd), 32'hABCD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
